// File: rtl/tick_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen_pkg
//  Description : Shared constants and per-channel operation encoding for the
//                tick_gen programmable tick / clock divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package tick_gen_pkg;

    localparam int c_W_DEFAULT = 20;
    localparam int c_N_CH_MAX  = 8;
    localparam int c_DIV_ZERO  = 0;

    // What a channel does on the coming clock edge, resolved in priority order.
    typedef enum logic [2:0] {
        OP_IDLE   = 3'd0,
        OP_APPLY  = 3'd1,
        OP_FREEZE = 3'd2,
        OP_COUNT  = 3'd3,
        OP_WRAP   = 3'd4,
        OP_SYNC   = 3'd5
    } ch_op_e;

endpackage
`default_nettype wire

// File: rtl/tick_gen_ch.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen_ch
//  Description : One divider channel: active/pending divisor, down-counter,
//                registered tick pulse and 50% square wave.
//                Optional phase-align input under TICK_GEN_SYNC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int W = c_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
`ifdef TICK_GEN_SYNC_EN
    input  logic         i_sync,
`endif
    input  logic         i_load,
    input  logic [W-1:0] i_div,
    output logic         o_tick,
    output logic         o_clk_out
);

    localparam logic [W-1:0] c_ZERO = W'(c_DIV_ZERO);
    localparam logic [W-1:0] c_ONE  = W'(1);

    logic [W-1:0] r_act;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_pend;
    logic         r_pend_vld;
    logic         r_tick;
    logic         r_clk_out;

    logic [W-1:0] w_next_div;
    logic [W-1:0] w_reload;
    ch_op_e       w_op;

    // A zero divisor reloads the counter with zero rather than wrapping to all ones.
    assign w_next_div = r_pend_vld ? r_pend : r_act;
    assign w_reload   = (w_next_div == c_ZERO) ? c_ZERO : (w_next_div - c_ONE);

    always_comb begin
        w_op = OP_IDLE;
        if (r_act == c_ZERO) begin
            if (r_pend_vld) begin
                w_op = OP_APPLY;
            end
        end
`ifdef TICK_GEN_SYNC_EN
        else if (i_sync) begin
            w_op = OP_SYNC;
        end
`endif
        else if (!i_en) begin
            w_op = OP_FREEZE;
        end else if (r_cnt != c_ZERO) begin
            w_op = OP_COUNT;
        end else begin
            w_op = OP_WRAP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act      <= c_ZERO;
            r_cnt      <= c_ZERO;
            r_pend     <= c_ZERO;
            r_pend_vld <= 1'b0;
            r_tick     <= 1'b0;
            r_clk_out  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (w_op)
                OP_APPLY: begin
                    r_act      <= r_pend;
                    r_cnt      <= w_reload;
                    r_pend_vld <= 1'b0;
                end
                OP_COUNT: begin
                    r_cnt <= r_cnt - c_ONE;
                end
                OP_WRAP: begin
                    r_tick     <= 1'b1;
                    r_clk_out  <= ~r_clk_out;
                    r_act      <= w_next_div;
                    r_cnt      <= w_reload;
                    r_pend_vld <= 1'b0;
                end
`ifdef TICK_GEN_SYNC_EN
                OP_SYNC: begin
                    r_cnt     <= r_act - c_ONE;
                    r_clk_out <= 1'b0;
                end
`endif
                default: begin
                end
            endcase
            // A load arriving with a wrap/apply is kept pending for the next one.
            if (i_load) begin
                r_pend     <= i_div;
                r_pend_vld <= 1'b1;
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_clk_out = r_clk_out;

endmodule
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : N_CH independent programmable tick generators / clock
//                dividers. Define TICK_GEN_SYNC_EN to add the sync input.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int W    = c_W_DEFAULT
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              en,
`ifdef TICK_GEN_SYNC_EN
    input  logic              sync,
`endif
    input  logic [N_CH*W-1:0] div,
    input  logic [N_CH-1:0]   load,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   clk_out
);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        if (k < c_N_CH_MAX) begin : g_inst
            tick_gen_ch #(
                .W (W)
            ) u_ch (
                .clk       (mclk),
                .rst       (rst),
                .i_en      (en),
`ifdef TICK_GEN_SYNC_EN
                .i_sync    (sync),
`endif
                .i_load    (load[k]),
                .i_div     (div[k*W +: W]),
                .o_tick    (tick[k]),
                .o_clk_out (clk_out[k])
            );
        end else begin : g_tie
            // Channels beyond the supported count stay permanently idle.
            assign tick[k]    = 1'b0;
            assign clk_out[k] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_gen
//  Description : Directed self-checking bench for tick_gen (N_CH=2, W=20).
//                Exercises the sync input when TICK_GEN_SYNC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_gen;

    localparam int N_CH = 2;
    localparam int W    = 20;

    logic              mclk = 1'b0;
    logic              rst  = 1'b1;
    logic              en   = 1'b0;
    logic [N_CH*W-1:0] div  = '0;
    logic [N_CH-1:0]   load = '0;
    logic [N_CH-1:0]   tick;
    logic [N_CH-1:0]   clk_out;
`ifdef TICK_GEN_SYNC_EN
    logic              sync = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    tick_gen #(
        .N_CH (N_CH),
        .W    (W)
    ) dut (
        .mclk    (mclk),
        .rst     (rst),
        .en      (en),
`ifdef TICK_GEN_SYNC_EN
        .sync    (sync),
`endif
        .div     (div),
        .load    (load),
        .tick    (tick),
        .clk_out (clk_out)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic load_ch(input int ch, input int d);
        load = '0;
        load[ch] = 1'b1;
        div[ch*W +: W] = W'(d);
        step(1);
        load = '0;
    endtask

    // Steps until tick[ch] is seen; n = edges taken, or -1 if the budget ran out.
    task automatic wait_tick(input int ch, input int budget, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (tick[ch] !== 1'b1 && n < budget);
        if (tick[ch] !== 1'b1) n = -1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        en   = 1'b0;
        load = '0;
        div  = '0;
`ifdef TICK_GEN_SYNC_EN
        sync = 1'b0;
`endif
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        int n;
        int bad;

        // ---- reset state, halted until loaded, div=5 on ch0 ----
        do_reset();
        check("rst_tick", tick, 0);
        check("rst_clk", clk_out, 0);
        en = 1'b1;
        step(3);
        check("halt_no_tick", tick, 0);
        load_ch(0, 5);
        wait_tick(0, 30, n);
        check("t1_first", n, 6);
        check("t1_clk_hi", clk_out[0], 1);
        check("t1_ch1_idle", {tick[1], clk_out[1]}, 0);
        step(1);
        check("t1_pulse_1cyc", tick[0], 0);
        wait_tick(0, 30, n);
        check("t1_gap_a", n, 4);
        check("t1_clk_lo", clk_out[0], 0);
        wait_tick(0, 30, n);
        check("t1_gap_b", n, 5);
        check("t1_clk_hi2", clk_out[0], 1);
        check("t1_ch1_idle2", {tick[1], clk_out[1]}, 0);
        step(2);
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (tick[0] !== 1'b0 || clk_out[0] !== 1'b1) bad++;
        end
        check("t1_freeze", bad, 0);
        en = 1'b1;
        wait_tick(0, 30, n);
        check("t1_resume", n, 3);
        check("t1_resume_clk", clk_out[0], 0);

        // ---- div 4 -> 7 loaded two cycles before wrap ----
        do_reset();
        en = 1'b1;
        load_ch(0, 4);
        wait_tick(0, 30, n);
        check("t2_first", n, 5);
        step(1);
        load_ch(0, 7);
        wait_tick(0, 30, n);
        check("t2_gap_old", n + 2, 4);
        wait_tick(0, 30, n);
        check("t2_gap_new_a", n, 7);
        wait_tick(0, 30, n);
        check("t2_gap_new_b", n, 7);

        // ---- div 3 -> 6 loaded on the wrap cycle ----
        do_reset();
        en = 1'b1;
        load_ch(0, 3);
        wait_tick(0, 30, n);
        check("t3_first", n, 4);
        step(2);
        load_ch(0, 6);
        check("t3_coinc_tick", tick[0], 1);
        wait_tick(0, 30, n);
        check("t3_gap_old", n, 3);
        wait_tick(0, 30, n);
        check("t3_gap_new_a", n, 6);
        wait_tick(0, 30, n);
        check("t3_gap_new_b", n, 6);

        // ---- div=1 continuous ticks, freeze and resume ----
        do_reset();
        en = 1'b1;
        load_ch(0, 1);
        wait_tick(0, 30, n);
        check("t4_first", n, 2);
        check("t4_first_clk", clk_out[0], 1);
        bad = 0;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            if (tick[0] !== 1'b1 || clk_out[0] !== ((i % 2) == 0)) bad++;
        end
        check("t4_div1", bad, 0);
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (tick[0] !== 1'b0 || clk_out[0] !== 1'b1) bad++;
        end
        check("t4_freeze", bad, 0);
        en = 1'b1;
        step(1);
        check("t4_resume", {tick[0], clk_out[0]}, 2'b10);

        // ---- load 0 into running ch1, then reset mid-count ----
        do_reset();
        en = 1'b1;
        load_ch(1, 3);
        wait_tick(1, 30, n);
        check("t5_first", n, 4);
        wait_tick(1, 30, n);
        check("t5_gap", n, 3);
        check("t5_clk_lo", clk_out[1], 0);
        load_ch(1, 0);
        wait_tick(1, 30, n);
        check("t5_last_tick", n, 2);
        check("t5_last_clk", clk_out[1], 1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (tick[1] !== 1'b0 || clk_out[1] !== 1'b1 || tick[0] !== 1'b0) bad++;
        end
        check("t5_halted", bad, 0);
        load_ch(0, 2);
        wait_tick(0, 30, n);
        check("t5_ch0_first", n, 3);
        load_ch(1, 4);
        check("t5_pre_rst_clk", clk_out, 2'b11);
        rst = 1'b1;
        #1;
        check("t5_rst_async", {tick, clk_out}, 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (tick !== 2'b00 || clk_out !== 2'b00) bad++;
        end
        check("t5_post_rst", bad, 0);

`ifdef TICK_GEN_SYNC_EN
        // ---- sync aligns ch0 (div 4) and ch1 (div 8) ----
        do_reset();
        en = 1'b1;
        load_ch(0, 4);
        step(2);
        load_ch(1, 8);
        step(1);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        check("t6_sync_out", {tick, clk_out}, 0);
        step(3);
        check("t6_no_early", tick, 2'b00);
        step(1);
        check("t6_tick4", tick, 2'b01);
        step(4);
        check("t6_tick8", tick, 2'b11);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
